// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one combinational ALU.
// Each operation is launched from registered operands and its result returns one cycle later.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_O,
  input  logic             alu_C,
  input  logic             alu_Z,
  input  logic             alu_N,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_y,
  output logic [3:0]       rsp_flags,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t           r_state;
  logic             r_ptr;
  logic             r_owner;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OPW-1:0]   r_alu_op;
  logic [WIDTH-1:0] r_rsp_y;
  logic [3:0]       r_rsp_flags;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic             r_busy;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;

  // Handshake: a request transfers on the rising edge where valid and ready are both high;
  // ready depends on valid, never the reverse, and responses are unconditional one-cycle pulses.
  assign w_idle   = (r_state == IDLE) && !rst;
  assign w_grant0 = w_idle && req0_valid && (!req1_valid || !r_ptr);
  assign w_grant1 = w_idle && req1_valid && (!req0_valid ||  r_ptr);

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_y      = r_rsp_y;
  assign rsp_flags  = r_rsp_flags;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign busy       = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= 1'b0;
      r_owner      <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_y      <= '0;
      r_rsp_flags  <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_alu_a  <= w_grant1 ? req1_a  : req0_a;
            r_alu_b  <= w_grant1 ? req1_b  : req0_b;
            r_alu_op <= w_grant1 ? req1_op : req0_op;
            r_owner  <= w_grant1;
            // Priority moves to whoever lost this round.
            r_ptr    <= w_grant0;
            r_state  <= EXEC;
            r_busy   <= 1'b1;
          end
        end
        EXEC: begin
          r_rsp_y      <= alu_y;
          r_rsp_flags  <= {alu_O, alu_C, alu_Z, alu_N};
          r_rsp0_valid <= !r_owner;
          r_rsp1_valid <= r_owner;
          r_state      <= IDLE;
          r_busy       <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: ALU stub, arbitration model with an expected-result queue,
// directed scenarios followed by random traffic.
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int OPW   = 3;
  localparam int EW    = WIDTH + 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0]   req0_op, req1_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [OPW-1:0]   alu_op;
  logic             alu_O, alu_C, alu_Z, alu_N;
  logic             rsp0_valid, rsp1_valid, busy;
  logic [WIDTH-1:0] rsp_y;
  logic [3:0]       rsp_flags;

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .alu_O(alu_O), .alu_C(alu_C), .alu_Z(alu_Z), .alu_N(alu_N),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_y(rsp_y),
    .rsp_flags(rsp_flags), .busy(busy)
  );

  // ALU stub: op 1 subtracts, every other op adds. Returns {y, O, C, Z, N}.
  function automatic logic [WIDTH+3:0] alu_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [OPW-1:0] op);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] y;
    logic             o;
    if (op == 3'd1) begin
      s = {1'b0, a} - {1'b0, b};
      y = s[WIDTH-1:0];
      o = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
    end else begin
      s = {1'b0, a} + {1'b0, b};
      y = s[WIDTH-1:0];
      o = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
    end
    return {y, o, s[WIDTH], (y == '0), y[WIDTH-1]};
  endfunction

  assign {alu_y, alu_O, alu_C, alu_Z, alu_N} = alu_model(alu_a, alu_b, alu_op);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of arbitration and sequencing, sampled on the falling edge.
  logic             m_busy, m_ptr, m_due;
  logic [WIDTH-1:0] m_a, m_b;
  logic [OPW-1:0]   m_op;

  always @(negedge clk) begin
    logic          g0, g1;
    logic [EW-1:0] e;
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = 1'b0;
      m_due  = 1'b0;
      exp_q.delete();
      check("rst_ready", {req1_ready, req0_ready}, 2'b00);
      check("rst_rsp", {rsp1_valid, rsp0_valid, busy}, 3'b000);
    end else begin
      check("rsp_pulse", rsp0_valid | rsp1_valid, m_due);
      if (m_due && (rsp0_valid || rsp1_valid)) begin
        if (exp_q.size() == 0) begin
          check("rsp_queue", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_owner", {rsp1_valid, rsp0_valid}, e[EW-1] ? 2'b10 : 2'b01);
          check("rsp_y", rsp_y, e[WIDTH+3:4]);
          check("rsp_flags", rsp_flags, e[3:0]);
        end
      end
      m_due = 1'b0;
      if (m_busy) begin
        check("exec_busy", busy, 1);
        check("exec_ready", {req1_ready, req0_ready}, 2'b00);
        check("exec_alu_a", alu_a, m_a);
        check("exec_alu_b", alu_b, m_b);
        check("exec_alu_op", alu_op, m_op);
        m_busy = 1'b0;
        m_due  = 1'b1;
      end else begin
        g0 = req0_valid && (!req1_valid || !m_ptr);
        g1 = req1_valid && (!req0_valid ||  m_ptr);
        check("idle_busy", busy, 0);
        check("idle_ready", {req1_ready, req0_ready}, {g1, g0});
        if (g0 || g1) begin
          m_a  = g1 ? req1_a  : req0_a;
          m_b  = g1 ? req1_b  : req0_b;
          m_op = g1 ? req1_op : req0_op;
          exp_q.push_back({g1, alu_model(m_a, m_b, m_op)});
          m_ptr  = g0;
          m_busy = 1'b1;
        end
      end
    end
  end

  task automatic set0(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [OPW-1:0] op);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic set1(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [OPW-1:0] op);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Lone request from port p issued in an idle cycle; checks the cycle-by-cycle latency.
  task automatic single_op(input logic p, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [OPW-1:0] op, input logic [WIDTH-1:0] ey, input logic [3:0] ef);
    if (p) set1(1'b1, a, b, op); else set0(1'b1, a, b, op);
    @(negedge clk); check("op_ready", p ? req1_ready : req0_ready, 1);
    @(posedge clk); #1;
    if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
    @(negedge clk);
    check("op_alu_a", alu_a, a);
    check("op_alu_b", alu_b, b);
    check("op_busy", busy, 1);
    @(negedge clk);
    check("op_rsp_valid", {rsp1_valid, rsp0_valid}, p ? 2'b10 : 2'b01);
    check("op_rsp_y", rsp_y, ey);
    check("op_rsp_flags", rsp_flags, ef);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_alu_a", alu_a, 0);
    check("reset_rsp_y", rsp_y, 0);

    // Single request, then flag cases.
    single_op(1'b0, 32'd5, 32'd7, 3'd0, 32'd12, 4'b0000);
    single_op(1'b1, 32'h7FFF_FFFF, 32'd1, 3'd0, 32'h8000_0000, 4'b1001);
    single_op(1'b1, 32'd3, 32'd3, 3'd1, 32'd0, 4'b0010);

    // Contention from a fresh pointer: grants alternate 0,1,0,1.
    do_reset();
    set0(1'b1, 32'd3, 32'd4, 3'd0);
    set1(1'b1, 32'd10, 32'd3, 3'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cont_ready0", req0_ready, (i % 2) == 0);
      check("cont_ready1", req1_ready, (i % 2) == 1);
      if (i > 0) begin
        check("cont_rsp1", {rsp1_valid, rsp0_valid}, ((i % 2) == 0) ? 2'b10 : 2'b01);
        check("cont_rsp_y", rsp_y, 32'd7);
      end
      @(negedge clk);
      check("cont_exec_ready", {req1_ready, req0_ready}, 2'b00);
    end
    @(posedge clk); #1;
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
    repeat (2) @(posedge clk); #1;

    // Asynchronous reset mid-cycle; pointer was left at 1 by the last grant to requester 0.
    single_op(1'b0, 32'h1234, 32'd1, 3'd2, 32'h1235, 4'b0000);
    set0(1'b1, 32'd20, 32'd1, 3'd0);
    set1(1'b1, 32'd30, 32'd1, 3'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_alu_a", alu_a, 0);
    check("arst_alu_b", alu_b, 0);
    check("arst_alu_op", alu_op, 0);
    check("arst_rsp_y", rsp_y, 0);
    check("arst_rsp_flags", rsp_flags, 0);
    check("arst_ready", {req1_ready, req0_ready}, 2'b00);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("arst_first_grant", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
    repeat (3) @(posedge clk); #1;

    // Reset while an operation is in EXEC drops it and returns the pointer to 0.
    single_op(1'b0, 32'd1, 32'd2, 3'd0, 32'd3, 4'b0000);
    set0(1'b1, 32'd40, 32'd2, 3'd0);
    @(negedge clk); check("drop_ready0", req0_ready, 1);
    @(posedge clk); #1 set0(1'b0, '0, '0, '0);
    #2 rst = 1'b1;
    #1 check("drop_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    set0(1'b1, 32'd50, 32'd5, 3'd1);
    set1(1'b1, 32'd60, 32'd6, 3'd1);
    @(negedge clk);
    check("drop_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
    check("drop_grant0", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1 set0(1'b0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk); check("drop_grant1", req1_ready, 1);
    @(posedge clk); #1 set1(1'b0, '0, '0, '0);
    repeat (3) @(posedge clk); #1;

    // A waiting requester may change operands before its own grant.
    do_reset();
    set0(1'b1, 32'd4, 32'd4, 3'd0);
    set1(1'b1, 32'd1, 32'd1, 3'd0);
    @(negedge clk); check("hold_grant0", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    set0(1'b0, '0, '0, '0);
    set1(1'b1, 32'd9, 32'd2, 3'd1);
    @(negedge clk);
    @(negedge clk); check("hold_grant1", req1_ready, 1);
    @(posedge clk); #1 set1(1'b0, '0, '0, '0);
    @(negedge clk);
    check("hold_alu_a", alu_a, 32'd9);
    check("hold_alu_b", alu_b, 32'd2);
    @(negedge clk);
    check("hold_rsp1", rsp1_valid, 1);
    check("hold_rsp_y", rsp_y, 32'd7);
    @(posedge clk); #1;

    // Random traffic, checked entirely by the model.
    for (int i = 0; i < 300; i++) begin
      set0(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 1)));
      set1(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        req0_a = 32'h7FFF_FFFF;
        req1_b = req1_a;
      end
      @(posedge clk); #1;
    end
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("drain_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
